// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
// Holds the FSM state encoding and the beat-counter limits.
package bus_rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational round-robin search over a request vector.
// The search starts one past last_i and wraps modulo N_REQ.
module rr_pick
  import bus_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] pick_o,
  output logic             valid_o
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    pick_o  = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = IDX_W'((int'(last_i) + off) % N_REQ);
      if (!valid_o && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Packet-granular round-robin arbiter for a shared valid/ready bus.
// An owner holds the bus until a transferred beat carries last.
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        s_valid_i,
  input  logic [N_REQ*DATA_W-1:0] s_data_i,
  input  logic [N_REQ-1:0]        s_last_i,
  output logic [N_REQ-1:0]        s_ready_o,
  output logic                    m_valid_o,
  output logic [DATA_W-1:0]       m_data_o,
  output logic                    m_last_o,
  input  logic                    m_ready_i,
  output logic [N_REQ-1:0]        grant_o,
  output logic [CNT_W-1:0]        beat_cnt_o
);

  localparam int IDX_W = $clog2(N_REQ);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] own_idx;
  logic [N_REQ-1:0] pick;
  logic             pick_vld;
  logic             xfer;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (s_valid_i),
    .last_i  (last_q),
    .pick_o  (pick),
    .valid_o (pick_vld)
  );

  // grant_q is zero in IDLE, so the bus reads back all zeros there
  always_comb begin
    m_valid_o = 1'b0;
    m_last_o  = 1'b0;
    m_data_o  = '0;
    own_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_q[k]) begin
        m_valid_o = s_valid_i[k];
        m_last_o  = s_last_i[k];
        m_data_o  = s_data_i[k*DATA_W +: DATA_W];
        own_idx   = IDX_W'(k);
      end
    end
  end

  assign s_ready_o  = grant_q & {N_REQ{m_ready_i}};
  assign xfer       = m_valid_o & m_ready_i;
  assign grant_o    = grant_q;
  assign beat_cnt_o = cnt_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (pick_vld) begin
          state_d = BURST;
          grant_d = pick;
          cnt_d   = '0;
        end
      end
      (state_q == BURST): begin
        if (xfer && m_last_o) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = own_idx;
          cnt_d   = '0;
        end else if (xfer && cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // last_q resets to the top index so requester 0 searches first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter with per-requester sources
// and an in-order scoreboard of expected bus beats.
module tb_bus_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int DEPTH = 1024;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   s_valid_i;
  logic [N*W-1:0] s_data_i;
  logic [N-1:0]   s_last_i;
  logic [N-1:0]   s_ready_o;
  logic           m_valid_o;
  logic [W-1:0]   m_data_o;
  logic           m_last_o;
  logic           m_ready_i;
  logic [N-1:0]   grant_o;
  logic [7:0]     beat_cnt_o;

  bus_rr_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid_i  (s_valid_i),
    .s_data_i   (s_data_i),
    .s_last_i   (s_last_i),
    .s_ready_o  (s_ready_o),
    .m_valid_o  (m_valid_o),
    .m_data_o   (m_data_o),
    .m_last_o   (m_last_o),
    .m_ready_i  (m_ready_i),
    .grant_o    (grant_o),
    .beat_cnt_o (beat_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] g;
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  beat_t      sb[$];
  logic [W:0] src [N][DEPTH];
  int         hd [N];
  int         tl [N];
  logic [N-1:0] hold;
  logic [N-1:0] acc;
  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_pkt(input int k, input int n, input logic [W-1:0] d0);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.g = N'(1) << k;
      b.d = d0 + W'(i);
      b.l = (i == n - 1);
      src[k][tl[k] % DEPTH] = {b.l, b.d};
      tl[k]++;
      sb.push_back(b);
    end
  endtask

  task automatic flush();
    hold = '0;
    for (int k = 0; k < N; k++) hd[k] = tl[k];
    sb.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush();
    @(negedge clk);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_s_ready", 32'(s_ready_o), 32'd0);
    chk("rst_m_valid", 32'(m_valid_o), 32'd0);
    chk("rst_m_data", 32'(m_data_o), 32'd0);
    chk("rst_m_last", 32'(m_last_o), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && grant_o == '0) break;
      @(negedge clk);
    end
    chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    chk({tag, "_grant_end"}, 32'(grant_o), 32'd0);
  endtask

  task automatic wait_grant(input string tag, input logic [N-1:0] g);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant_o == g) break;
    end
    chk(tag, 32'(grant_o), 32'(g));
  endtask

  // acc marks beats that will be taken on the coming rising edge
  initial forever begin
    @(negedge clk);
    acc = s_valid_i & s_ready_o & {N{~rst}};
  end

  initial begin
    s_valid_i = '0;
    s_data_i  = '0;
    s_last_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        logic [W:0] f;
        if (acc[k] && hd[k] != tl[k]) hd[k]++;
        f = src[k][hd[k] % DEPTH];
        s_valid_i[k] = (hd[k] != tl[k]) && !hold[k];
        s_data_i[k*W +: W] = (hd[k] != tl[k]) ? f[W-1:0] : '0;
        s_last_i[k] = (hd[k] != tl[k]) && f[W];
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && m_valid_o && m_ready_i) begin
      n_assert++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_underflow observed=%0h expected=empty", grant_o);
      end
      if (sb.size() > 0) begin
        beat_t b;
        b = sb.pop_front();
        chk("bus_grant", 32'(grant_o), 32'(b.g));
        chk("bus_data", 32'(m_data_o), 32'(b.d));
        chk("bus_last", 32'(m_last_o), 32'(b.l));
        chk("bus_s_ready", 32'(s_ready_o), 32'(b.g));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt;
    int peak;
    rst = 1'b1;
    m_ready_i = 1'b1;
    hold = '0;
    acc = '0;
    for (int k = 0; k < N; k++) begin
      hd[k] = 0;
      tl[k] = 0;
    end

    // two simultaneous requests: 0 then 2, idle cycle between
    do_reset();
    @(negedge clk);
    add_pkt(0, 1, 8'hA0);
    add_pkt(2, 1, 8'hC2);
    @(negedge clk);
    chk("a_idle_lat", 32'(grant_o), 32'd0);
    @(negedge clk);
    chk("a_grant0", 32'(grant_o), 32'b0001);
    @(negedge clk);
    chk("a_gap", 32'(grant_o), 32'd0);
    chk("a_gap_valid", 32'(m_valid_o), 32'd0);
    @(negedge clk);
    chk("a_grant2", 32'(grant_o), 32'b0100);
    drain("a", 20);

    // everyone requesting: 0,1,2,3 then wrap to 0,1
    do_reset();
    @(negedge clk);
    add_pkt(0, 1, 8'h30);
    add_pkt(1, 1, 8'h31);
    add_pkt(2, 1, 8'h32);
    add_pkt(3, 1, 8'h33);
    add_pkt(0, 1, 8'h34);
    add_pkt(1, 1, 8'h35);
    drain("b", 40);

    // 3-beat packet with a 2-cycle sink stall after beat 1
    do_reset();
    @(negedge clk);
    add_pkt(1, 3, 8'h11);
    @(negedge clk);
    chk("c_idle", 32'(grant_o), 32'd0);
    @(negedge clk);
    chk("c_d1", 32'(m_data_o), 32'h11);
    chk("c_cnt0", 32'(beat_cnt_o), 32'd0);
    @(posedge clk);
    #1 m_ready_i = 1'b0;
    @(negedge clk);
    chk("c_d_st1", 32'(m_data_o), 32'h12);
    chk("c_cnt1a", 32'(beat_cnt_o), 32'd1);
    chk("c_ready_st", 32'(s_ready_o), 32'd0);
    @(negedge clk);
    chk("c_d_st2", 32'(m_data_o), 32'h12);
    chk("c_cnt1b", 32'(beat_cnt_o), 32'd1);
    @(posedge clk);
    #1 m_ready_i = 1'b1;
    @(negedge clk);
    chk("c_d2", 32'(m_data_o), 32'h12);
    chk("c_cnt1c", 32'(beat_cnt_o), 32'd1);
    @(negedge clk);
    chk("c_d3", 32'(m_data_o), 32'h13);
    chk("c_cnt2", 32'(beat_cnt_o), 32'd2);
    @(negedge clk);
    chk("c_cnt_clr", 32'(beat_cnt_o), 32'd0);
    drain("c", 10);

    // owner 2 drops valid mid-packet while 3 waits
    do_reset();
    @(negedge clk);
    add_pkt(2, 4, 8'h20);
    add_pkt(3, 1, 8'h3F);
    wait_grant("d_grant2", 4'b0100);
    hold[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("d_hold_grant", 32'(grant_o), 32'b0100);
      chk("d_hold_valid", 32'(m_valid_o), 32'd0);
    end
    hold[2] = 1'b0;
    drain("d", 40);

    // reset during beat 2 of requester 1; priority restarts at 0
    @(negedge clk);
    add_pkt(0, 1, 8'h0E);
    add_pkt(1, 4, 8'h50);
    wait_grant("e_grant1", 4'b0010);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("e_rst_grant", 32'(grant_o), 32'd0);
    chk("e_rst_valid", 32'(m_valid_o), 32'd0);
    chk("e_rst_data", 32'(m_data_o), 32'd0);
    chk("e_rst_last", 32'(m_last_o), 32'd0);
    chk("e_rst_ready", 32'(s_ready_o), 32'd0);
    chk("e_rst_cnt", 32'(beat_cnt_o), 32'd0);
    flush();
    add_pkt(0, 1, 8'h0A);
    add_pkt(1, 1, 8'h1B);
    @(posedge clk);
    #1 rst = 1'b0;
    drain("e", 20);

    // long packet: counter saturates at 255 and still completes
    @(negedge clk);
    add_pkt(3, 300, 8'h00);
    wait_grant("f_grant3", 4'b1000);
    exp_cnt = 0;
    peak = 0;
    for (int i = 0; i < 400; i++) begin
      if (grant_o != 4'b1000) break;
      chk("f_cnt", 32'(beat_cnt_o), 32'(exp_cnt));
      if (int'(beat_cnt_o) > peak) peak = int'(beat_cnt_o);
      if (m_valid_o && m_ready_i) begin
        if (m_last_o) exp_cnt = 0;
        else if (exp_cnt < 255) exp_cnt++;
      end
      @(negedge clk);
    end
    chk("f_peak", 32'(peak), 32'd255);
    chk("f_cnt_end", 32'(beat_cnt_o), 32'd0);
    drain("f", 20);

    // single requester is granted packet after packet
    @(negedge clk);
    add_pkt(2, 1, 8'h71);
    add_pkt(2, 1, 8'h72);
    add_pkt(2, 1, 8'h73);
    drain("g", 30);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
